hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the five-stage core: selects the execute-stage operand forwarding muxes (forwardA/forwardB), generates the pipeline-register enables (freeze, pc_en, ifid_en), and generates the ID/EX bubble and branch flush. It sits beside the decode/execute/memory stages. It inspects their pipeline-register fields and the data-memory handshake, and owns the run/stall/halt state machine.

---
 rtl/hazard_ctrl_if.sv | 64 ++++++
 rtl/hazard_ctrl.sv | 157 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 397 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the pipeline stages and the hazard controller.
// The master side is the datapath; the slave side is hazard_ctrl.
interface hazard_ctrl_if;
    // Decode-stage fields
    logic [2:0]  RsA_ID;
    logic [2:0]  RsB_ID;
    logic        useA_ID;
    logic        useB_ID;
    logic        valid_ID;

    // ID/EX register fields
    logic [2:0]  RsA_IDEX;
    logic [2:0]  RsB_IDEX;
    logic        useA_IDEX;
    logic        useB_IDEX;
    logic [2:0]  WrR_IDEX;
    logic        RegWrite_IDEX;
    logic        MemRead_IDEX;

    // EX/MEM register fields
    logic [2:0]  WrR_EXMEM;
    logic        RegWrite_EXMEM;
    logic        MemRead_EXMEM;
    logic        MemWrite_EXMEM;
    logic        takeBranch_EXMEM;

    // MEM/WB register fields and data-memory handshake
    logic [2:0]  WrR_MEMWB;
    logic        RegWrite_MEMWB;
    logic        halt_MEMWB;
    logic        dmem_done;

    // Controls back to the datapath
    logic [1:0]  forwardA;
    logic [1:0]  forwardB;
    logic        freeze;
    logic        pc_en;
    logic        ifid_en;
    logic        bubble_IDEX;
    logic        flush;
    logic        halted;
    logic        err;
    logic [15:0] stall_cnt;

    modport master (
        output RsA_ID, RsB_ID, useA_ID, useB_ID, valid_ID,
        output RsA_IDEX, RsB_IDEX, useA_IDEX, useB_IDEX,
        output WrR_IDEX, RegWrite_IDEX, MemRead_IDEX,
        output WrR_EXMEM, RegWrite_EXMEM, MemRead_EXMEM, MemWrite_EXMEM, takeBranch_EXMEM,
        output WrR_MEMWB, RegWrite_MEMWB, halt_MEMWB, dmem_done,
        input  forwardA, forwardB, freeze, pc_en, ifid_en, bubble_IDEX, flush,
        input  halted, err, stall_cnt
    );

    modport slave (
        input  RsA_ID, RsB_ID, useA_ID, useB_ID, valid_ID,
        input  RsA_IDEX, RsB_IDEX, useA_IDEX, useB_IDEX,
        input  WrR_IDEX, RegWrite_IDEX, MemRead_IDEX,
        input  WrR_EXMEM, RegWrite_EXMEM, MemRead_EXMEM, MemWrite_EXMEM, takeBranch_EXMEM,
        input  WrR_MEMWB, RegWrite_MEMWB, halt_MEMWB, dmem_done,
        output forwardA, forwardB, freeze, pc_en, ifid_en, bubble_IDEX, flush,
        output halted, err, stall_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline sequencing: operand forwarding, stall/bubble/flush
// generation and the run / memory-wait / halt state machine.
module hazard_ctrl (
    input  logic         clk,
    input  logic         rst,
    hazard_ctrl_if.slave hz
);
    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MEMWAIT = 2'd1,
        ST_HALT    = 2'd2
    } state_t;

    localparam logic [3:0] TIMEOUT = 4'd15;

    state_t      state_q, state_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic        err_q, err_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Operand 0 is A, operand 1 is B; both follow identical rules.
    logic [2:0]  rs_idex [2];
    logic        use_idex [2];
    logic [1:0]  fwd_sel [2];
    logic [2:0]  rs_id [2];
    logic        use_id [2];
    logic [1:0]  src_hit;

    assign rs_idex[0]  = hz.RsA_IDEX;
    assign rs_idex[1]  = hz.RsB_IDEX;
    assign use_idex[0] = hz.useA_IDEX;
    assign use_idex[1] = hz.useB_IDEX;
    assign rs_id[0]    = hz.RsA_ID;
    assign rs_id[1]    = hz.RsB_ID;
    assign use_id[0]   = hz.useA_ID;
    assign use_id[1]   = hz.useB_ID;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            logic ex_hit;
            logic wb_hit;

            // A load in EX/MEM has no ALU result to forward; its data arrives via MEM/WB.
            assign ex_hit = use_idex[gi] & hz.RegWrite_EXMEM & ~hz.MemRead_EXMEM
                          & (hz.WrR_EXMEM == rs_idex[gi]);
            assign wb_hit = use_idex[gi] & hz.RegWrite_MEMWB
                          & (hz.WrR_MEMWB == rs_idex[gi]);

            assign fwd_sel[gi] = ex_hit ? 2'b10 : (wb_hit ? 2'b01 : 2'b00);
            assign src_hit[gi] = use_id[gi] & (rs_id[gi] == hz.WrR_IDEX);
        end
    endgenerate

    logic mem_busy;
    logic load_use;

    assign mem_busy = (hz.MemRead_EXMEM | hz.MemWrite_EXMEM) & ~hz.dmem_done;
    assign load_use = hz.valid_ID & hz.RegWrite_IDEX & hz.MemRead_IDEX & (|src_hit);

    logic freeze_c;
    logic pc_en_c;
    logic ifid_en_c;
    logic bubble_c;
    logic flush_c;

    always_comb begin
        freeze_c  = 1'b1;
        pc_en_c   = 1'b1;
        ifid_en_c = 1'b1;
        bubble_c  = 1'b0;
        flush_c   = 1'b0;
        if (state_q == ST_HALT) begin
            freeze_c  = 1'b0;
            pc_en_c   = 1'b0;
            ifid_en_c = 1'b0;
        end else if (mem_busy) begin
            freeze_c  = 1'b0;
            pc_en_c   = 1'b0;
            ifid_en_c = 1'b0;
        end else if (hz.takeBranch_EXMEM) begin
            // The flushed ID/EX slot makes any concurrent load-use moot.
            flush_c = 1'b1;
        end else if (load_use) begin
            pc_en_c   = 1'b0;
            ifid_en_c = 1'b0;
            bubble_c  = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = '0;
        err_d       = err_q;
        stall_cnt_d = stall_cnt_q;

        case (state_q)
            ST_RUN: begin
                if (mem_busy) begin
                    state_d = ST_MEMWAIT;
                end
            end
            ST_MEMWAIT: begin
                if (hz.dmem_done) begin
                    state_d = ST_RUN;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        // Halt only takes effect when the halting instruction actually retires.
        if (hz.halt_MEMWB & freeze_c) begin
            state_d = ST_HALT;
        end

        if ((state_q == ST_MEMWAIT) && (state_d == ST_MEMWAIT)) begin
            wait_cnt_d = (wait_cnt_q == TIMEOUT) ? wait_cnt_q : (wait_cnt_q + 4'd1);
            if (wait_cnt_d == TIMEOUT) begin
                err_d = 1'b1;
            end
        end

        if (!pc_en_c && (state_q != ST_HALT) && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= '0;
            err_q       <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            err_q       <= err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign hz.forwardA    = fwd_sel[0];
    assign hz.forwardB    = fwd_sel[1];
    assign hz.freeze      = freeze_c;
    assign hz.pc_en       = pc_en_c;
    assign hz.ifid_en     = ifid_en_c;
    assign hz.bubble_IDEX = bubble_c;
    assign hz.flush       = flush_c;
    assign hz.halted      = (state_q == ST_HALT);
    assign hz.err         = err_q;
    assign hz.stall_cnt   = stall_cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: vector table, directed multi-cycle sequences and
// randomized cycles checked against a behavioural model.
module tb_hazard_ctrl;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    hazard_ctrl_if hz_if ();

    hazard_ctrl u_dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz_if)
    );

    typedef struct packed {
        logic [2:0] rsa_id;
        logic [2:0] rsb_id;
        logic       usea_id;
        logic       useb_id;
        logic       valid_id;
        logic [2:0] rsa_idex;
        logic [2:0] rsb_idex;
        logic       usea_idex;
        logic       useb_idex;
        logic [2:0] wrr_idex;
        logic       rw_idex;
        logic       mr_idex;
        logic [2:0] wrr_exmem;
        logic       rw_exmem;
        logic       mr_exmem;
        logic       mw_exmem;
        logic       br_exmem;
        logic [2:0] wrr_memwb;
        logic       rw_memwb;
        logic       halt_memwb;
        logic       done;
    } in_t;

    // ctl = {freeze, pc_en, ifid_en, bubble_IDEX, flush}
    typedef struct {
        string      name;
        in_t        in;
        logic [1:0] fa;
        logic [1:0] fb;
        logic [4:0] ctl;
    } vec_t;

    int   tests = 0;
    int   fails = 0;
    in_t  cur;
    in_t  v;
    in_t  lu;
    vec_t tbl[$];

    // Behavioural model state
    bit m_halted      = 1'b0;
    bit m_waiting     = 1'b0;
    bit m_err         = 1'b0;
    int m_wait_cycles = 0;
    int m_stall       = 0;

    function automatic vec_t mkv(string n, in_t i, logic [1:0] fa, logic [1:0] fb, logic [4:0] ctl);
        vec_t e;
        e.name = n;
        e.in   = i;
        e.fa   = fa;
        e.fb   = fb;
        e.ctl  = ctl;
        return e;
    endfunction

    function automatic logic [1:0] m_fwd(logic use_it, logic [2:0] rs, in_t i);
        if (use_it && i.rw_exmem && !i.mr_exmem && i.wrr_exmem == rs) return 2'b10;
        if (use_it && i.rw_memwb && i.wrr_memwb == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic model_comb(input in_t i, input bit halted,
                              output logic [1:0] fa, output logic [1:0] fb, output logic [4:0] ctl);
        bit busy;
        bit luse;
        fa   = m_fwd(i.usea_idex, i.rsa_idex, i);
        fb   = m_fwd(i.useb_idex, i.rsb_idex, i);
        busy = (i.mr_exmem || i.mw_exmem) && !i.done;
        luse = i.valid_id && i.rw_idex && i.mr_idex &&
               ((i.usea_id && i.rsa_id == i.wrr_idex) || (i.useb_id && i.rsb_id == i.wrr_idex));
        if (halted || busy)   ctl = 5'b00000;
        else if (i.br_exmem)  ctl = 5'b11101;
        else if (luse)        ctl = 5'b10010;
        else                  ctl = 5'b11100;
    endtask

    task automatic model_edge();
        logic [1:0] fa;
        logic [1:0] fb;
        logic [4:0] ctl;
        bit busy;
        if (!rst) begin
            m_halted = 0; m_waiting = 0; m_wait_cycles = 0; m_err = 0; m_stall = 0;
        end else begin
            model_comb(cur, m_halted, fa, fb, ctl);
            busy = (cur.mr_exmem || cur.mw_exmem) && !cur.done;
            if (!ctl[3] && !m_halted && m_stall < 65535) m_stall++;
            if (m_halted) begin
                m_halted = 1;
            end else if (cur.halt_memwb && ctl[4]) begin
                m_halted = 1; m_waiting = 0; m_wait_cycles = 0;
            end else if (m_waiting) begin
                if (cur.done) begin
                    m_waiting = 0; m_wait_cycles = 0;
                end else begin
                    m_wait_cycles++;
                    if (m_wait_cycles >= 15) m_err = 1;
                end
            end else if (busy) begin
                m_waiting = 1; m_wait_cycles = 0;
            end
        end
    endtask

    function automatic logic [4:0] dut_ctl();
        return {hz_if.freeze, hz_if.pc_en, hz_if.ifid_en, hz_if.bubble_IDEX, hz_if.flush};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_in(input in_t i, input logic r);
        cur = i;
        rst = r;
        hz_if.RsA_ID           = i.rsa_id;
        hz_if.RsB_ID           = i.rsb_id;
        hz_if.useA_ID          = i.usea_id;
        hz_if.useB_ID          = i.useb_id;
        hz_if.valid_ID         = i.valid_id;
        hz_if.RsA_IDEX         = i.rsa_idex;
        hz_if.RsB_IDEX         = i.rsb_idex;
        hz_if.useA_IDEX        = i.usea_idex;
        hz_if.useB_IDEX        = i.useb_idex;
        hz_if.WrR_IDEX         = i.wrr_idex;
        hz_if.RegWrite_IDEX    = i.rw_idex;
        hz_if.MemRead_IDEX     = i.mr_idex;
        hz_if.WrR_EXMEM        = i.wrr_exmem;
        hz_if.RegWrite_EXMEM   = i.rw_exmem;
        hz_if.MemRead_EXMEM    = i.mr_exmem;
        hz_if.MemWrite_EXMEM   = i.mw_exmem;
        hz_if.takeBranch_EXMEM = i.br_exmem;
        hz_if.WrR_MEMWB        = i.wrr_memwb;
        hz_if.RegWrite_MEMWB   = i.rw_memwb;
        hz_if.halt_MEMWB       = i.halt_memwb;
        hz_if.dmem_done        = i.done;
        #3;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic check_model(input string tag);
        logic [1:0] fa;
        logic [1:0] fb;
        logic [4:0] ctl;
        model_comb(cur, m_halted, fa, fb, ctl);
        chk({tag, ".fwdA"},   32'(hz_if.forwardA),  32'(fa));
        chk({tag, ".fwdB"},   32'(hz_if.forwardB),  32'(fb));
        chk({tag, ".ctl"},    32'(dut_ctl()),       32'(ctl));
        chk({tag, ".halted"}, 32'(hz_if.halted),    32'(m_halted));
        chk({tag, ".err"},    32'(hz_if.err),       32'(m_err));
        chk({tag, ".stall"},  32'(hz_if.stall_cnt), 32'(m_stall));
    endtask

    task automatic fin(input string tag);
        check_model(tag);
        $display("[TB] %-16s rst=%b fa=%b fb=%b ctl=%b halted=%b err=%b stall=%0d",
                 tag, rst, hz_if.forwardA, hz_if.forwardB, dut_ctl(),
                 hz_if.halted, hz_if.err, hz_if.stall_cnt);
        tick();
    endtask

    task automatic do_reset();
        drive_in('0, 1'b0);
        tick();
    endtask

    function automatic in_t rnd_in();
        in_t         i;
        logic [63:0] r;
        r = {$urandom, $urandom};
        i = r[34:0];
        i.rsa_id     = 3'($urandom_range(0, 3));
        i.rsb_id     = 3'($urandom_range(0, 3));
        i.rsa_idex   = 3'($urandom_range(0, 3));
        i.rsb_idex   = 3'($urandom_range(0, 3));
        i.wrr_idex   = 3'($urandom_range(0, 3));
        i.wrr_exmem  = 3'($urandom_range(0, 3));
        i.wrr_memwb  = 3'($urandom_range(0, 3));
        i.br_exmem   = ($urandom_range(0, 3) == 0);
        i.halt_memwb = ($urandom_range(0, 39) == 0);
        return i;
    endfunction

    initial begin
        // Load-use base pattern: load to r5 in EX, decode reads r5 on B
        lu = '0;
        lu.mr_idex = 1; lu.rw_idex = 1; lu.wrr_idex = 3'd5;
        lu.rsb_id = 3'd5; lu.useb_id = 1; lu.valid_id = 1;

        v = '0;
        tbl.push_back(mkv("idle", v, 2'b00, 2'b00, 5'b11100));
        v = '0; v.usea_idex = 1; v.rsa_idex = 3; v.rw_exmem = 1; v.wrr_exmem = 3;
        v.rw_memwb = 1; v.wrr_memwb = 3;
        tbl.push_back(mkv("fwd_ex_pri", v, 2'b10, 2'b00, 5'b11100));
        v.mr_exmem = 1; v.done = 1;
        tbl.push_back(mkv("fwd_load_mask", v, 2'b01, 2'b00, 5'b11100));
        v = '0; v.useb_idex = 1; v.rsb_idex = 7; v.rw_memwb = 1; v.wrr_memwb = 7;
        tbl.push_back(mkv("fwd_b_wb", v, 2'b00, 2'b01, 5'b11100));
        v = '0; v.rsa_idex = 2; v.rw_exmem = 1; v.wrr_exmem = 2;
        tbl.push_back(mkv("fwd_unused", v, 2'b00, 2'b00, 5'b11100));
        v = '0; v.usea_idex = 1; v.useb_idex = 1; v.rw_exmem = 1;
        tbl.push_back(mkv("fwd_r0", v, 2'b10, 2'b10, 5'b11100));
        v = '0; v.usea_idex = 1; v.rsa_idex = 4; v.wrr_exmem = 4; v.wrr_memwb = 4;
        tbl.push_back(mkv("fwd_no_wr", v, 2'b00, 2'b00, 5'b11100));
        tbl.push_back(mkv("load_use_b", lu, 2'b00, 2'b00, 5'b10010));
        v = lu; v.valid_id = 0;
        tbl.push_back(mkv("lu_invalid", v, 2'b00, 2'b00, 5'b11100));
        v = lu; v.useb_id = 0; v.rsa_id = 5; v.usea_id = 0;
        tbl.push_back(mkv("lu_unused", v, 2'b00, 2'b00, 5'b11100));
        v = lu; v.rw_idex = 0;
        tbl.push_back(mkv("lu_no_wr", v, 2'b00, 2'b00, 5'b11100));
        v = '0; v.br_exmem = 1;
        tbl.push_back(mkv("branch", v, 2'b00, 2'b00, 5'b11101));
        v = lu; v.br_exmem = 1;
        tbl.push_back(mkv("branch_over_lu", v, 2'b00, 2'b00, 5'b11101));
        v = '0; v.mr_exmem = 1;
        tbl.push_back(mkv("mem_busy_rd", v, 2'b00, 2'b00, 5'b00000));
        v = lu; v.mw_exmem = 1; v.br_exmem = 1;
        tbl.push_back(mkv("busy_over_br", v, 2'b00, 2'b00, 5'b00000));
        v = '0; v.mw_exmem = 1; v.done = 1;
        tbl.push_back(mkv("mem_done", v, 2'b00, 2'b00, 5'b11100));

        do_reset();

        // Reset state
        drive_in('0, 1'b1);
        chk("rst.ctl", 32'(dut_ctl()), 32'h1C);
        chk("rst.fwdA", 32'(hz_if.forwardA), 0);
        chk("rst.halted", 32'(hz_if.halted), 0);
        chk("rst.err", 32'(hz_if.err), 0);
        chk("rst.stall", 32'(hz_if.stall_cnt), 0);
        fin("reset");

        // Combinational vector table, each from a fresh RUN state
        foreach (tbl[k]) begin
            drive_in(tbl[k].in, 1'b1);
            chk({tbl[k].name, ".fwdA"}, 32'(hz_if.forwardA), 32'(tbl[k].fa));
            chk({tbl[k].name, ".fwdB"}, 32'(hz_if.forwardB), 32'(tbl[k].fb));
            chk({tbl[k].name, ".ctl"},  32'(dut_ctl()),      32'(tbl[k].ctl));
            fin(tbl[k].name);
            do_reset();
        end

        // Load-use costs exactly one bubble and one stall count
        drive_in(lu, 1'b1);
        chk("lu.ctl", 32'(dut_ctl()), 32'h12);
        fin("lu_bubble");
        drive_in('0, 1'b1);
        chk("lu.after_ctl", 32'(dut_ctl()), 32'h1C);
        chk("lu.stall", 32'(hz_if.stall_cnt), 1);
        fin("lu_after");

        // Branch wins over load-use; flush lasts one cycle
        v = lu; v.br_exmem = 1;
        drive_in(v, 1'b1);
        chk("br.ctl", 32'(dut_ctl()), 32'h1D);
        fin("br_flush");
        drive_in('0, 1'b1);
        chk("br.after_flush", 32'(hz_if.flush), 0);
        fin("br_after");

        // Memory access: done on the 5th cycle holds the pipe 4 cycles
        do_reset();
        v = '0; v.mr_exmem = 1;
        for (int k = 0; k < 4; k++) begin
            drive_in(v, 1'b1);
            chk("mw.freeze_low", 32'(hz_if.freeze), 0);
            fin("memwait");
        end
        v.done = 1;
        drive_in(v, 1'b1);
        chk("mw.freeze_done", 32'(hz_if.freeze), 1);
        fin("mem_done");
        drive_in('0, 1'b1);
        chk("mw.stall", 32'(hz_if.stall_cnt), 4);
        fin("mem_idle");

        // 15 cycles without done: just under the timeout
        do_reset();
        v = '0; v.mr_exmem = 1;
        for (int k = 0; k < 15; k++) begin
            drive_in(v, 1'b1);
            fin("wait15");
        end
        v.done = 1;
        drive_in(v, 1'b1);
        chk("to15.err", 32'(hz_if.err), 0);
        fin("wait15_done");

        // 16 cycles without done: err sets and sticks past dmem_done
        do_reset();
        v = '0; v.mr_exmem = 1;
        for (int k = 0; k < 16; k++) begin
            drive_in(v, 1'b1);
            if (k == 15) chk("to16.err_pre", 32'(hz_if.err), 0);
            fin("wait16");
        end
        v.done = 1;
        drive_in(v, 1'b1);
        chk("to16.err", 32'(hz_if.err), 1);
        fin("wait16_done");
        drive_in('0, 1'b1);
        chk("to16.err_sticky", 32'(hz_if.err), 1);
        fin("wait16_idle");

        // Reset in the middle of a wait returns to RUN and clears err
        v = '0; v.mr_exmem = 1;
        for (int k = 0; k < 3; k++) begin
            drive_in(v, 1'b1);
            fin("mid_wait");
        end
        do_reset();
        drive_in('0, 1'b1);
        chk("midrst.freeze", 32'(hz_if.freeze), 1);
        chk("midrst.err", 32'(hz_if.err), 0);
        fin("mid_rst");
        for (int k = 0; k < 20; k++) begin
            drive_in('0, 1'b1);
            fin("post_rst_idle");
        end
        drive_in('0, 1'b1);
        chk("midrst.no_timeout", 32'(hz_if.err), 0);
        fin("post_rst_chk");

        // Halt when retiring, then stay stopped until reset
        do_reset();
        v = '0; v.halt_memwb = 1;
        drive_in(v, 1'b1);
        chk("halt.freeze", 32'(hz_if.freeze), 1);
        fin("halt_req");
        drive_in('0, 1'b1);
        chk("halt.halted", 32'(hz_if.halted), 1);
        chk("halt.ctl", 32'(dut_ctl()), 0);
        fin("halted");
        drive_in(lu, 1'b1);
        fin("halted_lu");
        drive_in('0, 1'b1);
        chk("halt.stall", 32'(hz_if.stall_cnt), 0);
        chk("halt.still", 32'(hz_if.halted), 1);
        fin("halted_idle");
        do_reset();
        drive_in('0, 1'b1);
        chk("halt.rst_halted", 32'(hz_if.halted), 0);
        chk("halt.rst_stall", 32'(hz_if.stall_cnt), 0);
        chk("halt.rst_ctl", 32'(dut_ctl()), 32'h1C);
        fin("halt_cleared");

        // halt_MEMWB during a memory stall does not halt
        v = '0; v.mr_exmem = 1; v.halt_memwb = 1;
        drive_in(v, 1'b1);
        chk("halt_busy.freeze", 32'(hz_if.freeze), 0);
        fin("halt_busy");
        drive_in('0, 1'b1);
        chk("halt_busy.halted", 32'(hz_if.halted), 0);
        fin("halt_busy_after");

        // Randomized cycles against the model
        do_reset();
        for (int n = 0; n < 400; n++) begin
            logic r;
            if (m_halted) r = ($urandom_range(0, 5) != 0);
            else          r = ($urandom_range(0, 79) != 0);
            drive_in(rnd_in(), r);
            fin("random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
